// File: rtl/armleocpu_tlb_plru_sweep_if.sv
// Command / resolve / write bundle for the round-robin TLB with power-on invalidate sweep.
interface armleocpu_tlb_plru_sweep_if #(
  parameter int ENTRIES_W = 4,
  parameter int WAYS_W    = 2
);
  logic [2:0]           command;
  logic                 busy;
  logic [19:0]          virtual_address;
  logic                 hit;
  logic [WAYS_W-1:0]    hit_way;
  logic [7:0]           accesstag_r;
  logic [21:0]          phys_r;
  logic [19:0]          virtual_address_w;
  logic [7:0]           accesstag_w;
  logic [21:0]          phys_w;
  logic [ENTRIES_W-1:0] invalidate_set_index;

  modport master (
    output command, virtual_address, virtual_address_w, accesstag_w, phys_w,
           invalidate_set_index,
    input  busy, hit, hit_way, accesstag_r, phys_r
  );

  modport slave (
    input  command, virtual_address, virtual_address_w, accesstag_w, phys_w,
           invalidate_set_index,
    output busy, hit, hit_way, accesstag_r, phys_r
  );
endinterface

// File: rtl/armleocpu_tlb_plru_sweep.sv
// Set-associative TLB with per-set round-robin victim pointers and a sweeping
// invalidate-all that also runs after every reset.

module mem_1w1r #(
  parameter int ELEMENTS_W = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  readenable,
  input  logic [ELEMENTS_W-1:0] readaddress,
  output logic [WIDTH-1:0]      readdata,
  input  logic                  writeenable,
  input  logic [ELEMENTS_W-1:0] writeaddress,
  input  logic [WIDTH-1:0]      writedata
);
  logic [WIDTH-1:0] storage [2**ELEMENTS_W];

  always_ff @(posedge clk) begin
    if (writeenable)
      storage[writeaddress] <= writedata;
  end

  // Read register only loads on request, so resolve results hold between lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      readdata <= '0;
    else if (readenable)
      readdata <= storage[readaddress];
  end
endmodule

module armleocpu_tlb_plru_sweep #(
  parameter int ENTRIES_W     = 4,
  parameter int WAYS_W        = 2,
  parameter int disable_debug = 0
) (
  input logic                       clk,
  input logic                       rst_n,
  armleocpu_tlb_plru_sweep_if.slave bus
);
  localparam int unsigned ENTRIES = 1 << ENTRIES_W;
  localparam int unsigned WAYS    = 1 << WAYS_W;
  localparam int          VTAG_W  = 20 - ENTRIES_W;
  localparam int          ENTRY_W = VTAG_W + 22;

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;
  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_RESOLVE = 3'd1,
    CMD_WRITE   = 3'd2,
    CMD_INV_SET = 3'd3,
    CMD_INV_ALL = 3'd4
  } cmd_t;

  state_t               state;
  logic                 busy_r;
  logic [ENTRIES_W-1:0] sweep_cnt;
  logic [WAYS_W-1:0]    victim [ENTRIES];
  logic [VTAG_W-1:0]    req_vtag;

  logic                 idle;
  logic                 cmd_resolve, cmd_write, cmd_inv_set, cmd_inv_all;
  logic [ENTRIES_W-1:0] set_r, set_w, at_waddr;
  logic [WAYS_W-1:0]    victim_cur;
  logic [7:0]           at_wdata;
  logic [WAYS-1:0]      entry_we, at_we;
  logic [ENTRY_W-1:0]   entry_rd [WAYS];
  logic [7:0]           at_rd    [WAYS];

  logic                 hit_c;
  logic [WAYS_W-1:0]    hit_way_c;
  logic [7:0]           accesstag_c;
  logic [21:0]          phys_c;

  assign idle        = (state == ST_IDLE);
  assign cmd_resolve = idle && (bus.command == CMD_RESOLVE);
  assign cmd_write   = idle && (bus.command == CMD_WRITE);
  assign cmd_inv_set = idle && (bus.command == CMD_INV_SET);
  assign cmd_inv_all = idle && (bus.command == CMD_INV_ALL);

  assign set_r      = bus.virtual_address[ENTRIES_W-1:0];
  assign set_w      = bus.virtual_address_w[ENTRIES_W-1:0];
  assign victim_cur = victim[set_w];

  // Accesstag arrays have three writers; sweep wins, then single-set invalidate, then WRITE.
  always_comb begin
    at_waddr = set_w;
    at_wdata = bus.accesstag_w;
    at_we    = '0;
    entry_we = '0;
    if (state == ST_SWEEP) begin
      at_waddr = sweep_cnt;
      at_wdata = '0;
      at_we    = '1;
    end else if (cmd_inv_set) begin
      at_waddr = bus.invalidate_set_index;
      at_wdata = '0;
      at_we    = '1;
    end else if (cmd_write) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (victim_cur == WAYS_W'(w)) begin
          entry_we[w] = 1'b1;
          at_we[w]    = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    mem_1w1r #(.ELEMENTS_W(ENTRIES_W), .WIDTH(ENTRY_W)) u_entry (
      .clk          (clk),
      .rst_n        (rst_n),
      .readenable   (cmd_resolve),
      .readaddress  (set_r),
      .readdata     (entry_rd[g]),
      .writeenable  (entry_we[g]),
      .writeaddress (set_w),
      .writedata    ({bus.virtual_address_w[19:ENTRIES_W], bus.phys_w})
    );

    mem_1w1r #(.ELEMENTS_W(ENTRIES_W), .WIDTH(8)) u_accesstag (
      .clk          (clk),
      .rst_n        (rst_n),
      .readenable   (cmd_resolve),
      .readaddress  (set_r),
      .readdata     (at_rd[g]),
      .writeenable  (at_we[g]),
      .writeaddress (at_waddr),
      .writedata    (at_wdata)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SWEEP;
      busy_r    <= 1'b1;
      sweep_cnt <= '0;
      req_vtag  <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++)
        victim[i] <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_resolve)
            req_vtag <= bus.virtual_address[19:ENTRIES_W];
          if (cmd_write)
            victim[set_w] <= victim_cur + WAYS_W'(1);
          if (cmd_inv_all) begin
            state     <= ST_SWEEP;
            busy_r    <= 1'b1;
            sweep_cnt <= '0;
          end
        end
        ST_SWEEP: begin
          if (sweep_cnt == '1) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
          end else begin
            sweep_cnt <= sweep_cnt + ENTRIES_W'(1);
          end
        end
        default: state <= ST_SWEEP;
      endcase
    end
  end

  // Hit select works on the held read registers; lowest matching way wins.
  always_comb begin
    hit_c       = 1'b0;
    hit_way_c   = '0;
    accesstag_c = '0;
    phys_c      = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit_c && at_rd[w][0] && (entry_rd[w][ENTRY_W-1:22] == req_vtag)) begin
        hit_c       = 1'b1;
        hit_way_c   = WAYS_W'(w);
        accesstag_c = at_rd[w];
        phys_c      = entry_rd[w][21:0];
      end
    end
  end

  assign bus.busy        = busy_r;
  assign bus.hit         = hit_c;
  assign bus.hit_way     = hit_way_c;
  assign bus.accesstag_r = accesstag_c;
  assign bus.phys_r      = phys_c;

  // Scope for simulation-only trace hooks; empty in synthesis builds.
  if (disable_debug == 0) begin : g_debug
  end
endmodule

// File: doc/armleocpu_tlb_plru_sweep.md
ARMLEOCPU_TLB_PLRU_SWEEP -- requirements
Module: armleocpu_tlb_plru_sweep

Interface
REQ-001 The block SHALL have a parameter ENTRIES_W, default 4, giving log2 of the sets per way (1..8).
REQ-002 The block SHALL have a parameter WAYS_W, default 2, giving log2 of the way count (1..3).
REQ-003 The block SHALL have a parameter disable_debug, default 0; nonzero suppresses simulation debug prints.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 command  in  3  0=NONE, 1=RESOLVE, 2=WRITE, 3=INVALIDATE_SET, 4=INVALIDATE_ALL, 5..7=NONE.
REQ-007 busy  out  1  sweep in progress; commands are ignored while high.
REQ-008 virtual_address  in  20  resolve VPN; set = [ENTRIES_W-1:0], vtag = [19:ENTRIES_W].
REQ-009 hit  out  1  resolve result.
REQ-010 hit_way  out  WAYS_W  index of the hitting way.
REQ-011 accesstag_r  out  8  access tag of the hitting entry; bit0 = valid.
REQ-012 phys_r  out  22  PPN of the hitting entry.
REQ-013 virtual_address_w  in  20  write VPN.
REQ-014 accesstag_w  in  8  write access tag.
REQ-015 phys_w  in  22  write PPN.
REQ-016 invalidate_set_index  in  ENTRIES_W  target set for INVALIDATE_SET.

Function
REQ-017 The block SHALL store, per way and set, a vtag (20-ENTRIES_W bits), an 8-bit accesstag and a 22-bit PPN, using mem_1w1r instances for the arrays.
REQ-018 RESOLVE accepted at edge N SHALL present hit/hit_way/accesstag_r/phys_r after edge N, valid in cycle N+1.
REQ-019 Resolve outputs SHALL hold until the next accepted RESOLVE, unchanged by intervening WRITE/INVALIDATE, including to the same set.
REQ-020 A way hits iff its accesstag[0]=1 and its stored vtag equals the registered request vtag.
REQ-021 On multiple hits, the lowest-indexed way SHALL win.
REQ-022 On a miss: hit=0, hit_way=0, accesstag_r=0, phys_r=0.
REQ-023 WRITE SHALL write all three fields into way victim[set_w] of set set_w; accesstag_w is written as given, including bit0=0.
REQ-024 Each set SHALL have its own WAYS_W-bit round-robin victim pointer, incremented modulo WAYS after each accepted WRITE to that set; other sets' pointers are unchanged.
REQ-025 A WRITE at edge N SHALL be visible to a RESOLVE accepted at edge N+1.
REQ-026 INVALIDATE_SET SHALL clear the accesstag of set invalidate_set_index in every way in one cycle; victim pointers are unchanged.
REQ-027 INVALIDATE_ALL accepted at edge N SHALL set busy=1 from cycle N+1, clear the accesstags of set k in all ways during sweep cycle k (k=0..ENTRIES-1), then drop busy; busy is high for exactly ENTRIES cycles.
REQ-028 The FSM SHALL have states IDLE and SWEEP; IDLE->SWEEP on accepted INVALIDATE_ALL or reset release; SWEEP->IDLE after clearing set ENTRIES-1.
REQ-029 Commands presented while busy=1 SHALL have no effect on arrays, pointers or resolve outputs.
REQ-030 The sweep counter SHALL be ENTRIES_W bits wide and end at ENTRIES-1 without wrapping.
REQ-031 INVALIDATE_ALL SHALL NOT reset victim pointers.

Reset
REQ-032 While rst_n=0: state=SWEEP, sweep counter=0, busy=1, all victim pointers=0, hit=0, hit_way=0, accesstag_r=0, phys_r=0.
REQ-033 After rst_n rises, the block SHALL perform a full sweep (ENTRIES cycles busy) before accepting commands.
REQ-034 Reset asserted mid-sweep or mid-operation SHALL restart the sweep at set 0; no partial write completes after reset assertion.

Verification
REQ-035 Reset release, ENTRIES_W=4 -> busy high exactly 16 cycles; then RESOLVE of any VPN -> hit=0, outputs 0.
REQ-036 WRITE VPN 0x00013, tag 0x01, PPN 0x3ABCD; next cycle RESOLVE 0x00013 -> hit=1, hit_way=0, phys_r=0x3ABCD, accesstag_r=0x01; RESOLVE 0x00023 -> hit=0.
REQ-037 Five WRITEs to set 3 (WAYS=4), VPNs 0x00013..0x00053 -> fifth lands in way 0, 0x00013 misses, 0x00053 hits hit_way=0; a WRITE to set 4 lands in way 0.
REQ-038 Fill sets 2 and 5, INVALIDATE_SET 2 -> set-2 resolves miss, set-5 resolves hit; RESOLVE then INVALIDATE_SET of the same set -> held hit stays 1.
REQ-039 INVALIDATE_ALL, issue WRITE and RESOLVE while busy -> ignored, busy high 16 cycles, all prior entries miss afterward, victim pointers preserved.
REQ-040 Assert rst_n at sweep cycle 7 -> busy stays high, sweep restarts at set 0, 16 busy cycles after release.
